// File: rtl/csa_pkg.sv
// ---------------------------------------------------------------------------
// csa_pkg
//   Shared types and helpers for the chunked serial adder.
//   - state_t   : FSM state encoding {IDLE, ADD, DONE}, 2 bits
//   - cnt_width : width of the chunk counter, never less than one bit
// ---------------------------------------------------------------------------
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        DONE = 2'b10
    } state_t;

    // A single-chunk configuration still needs a 1-bit counter so that
    // the counter vector is never zero-width.
    function automatic int cnt_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage : csa_pkg

// File: rtl/chunked_serial_adder_if.sv
// ---------------------------------------------------------------------------
// chunked_serial_adder_if
//   Operand and result handshakes of the chunked serial adder.
//   Parameter WIDTH : operand / sum width.
//   Operand side : in_valid, in_ready, in1, in2, cin, sub (sub only when the
//                  CSA_SUB_EN macro is defined)
//   Result side  : out_valid, out_ready, sum, carry
//   master : the side that supplies operands and consumes results
//   slave  : the adder itself
// ---------------------------------------------------------------------------
interface chunked_serial_adder_if #(
    parameter int WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             cin;
`ifdef CSA_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;

    modport master (
`ifdef CSA_SUB_EN
        output sub,
`endif
        output in_valid, in1, in2, cin, out_ready,
        input  in_ready, out_valid, sum, carry
    );

    modport slave (
`ifdef CSA_SUB_EN
        input  sub,
`endif
        input  in_valid, in1, in2, cin, out_ready,
        output in_ready, out_valid, sum, carry
    );

endinterface : chunked_serial_adder_if

// File: rtl/chunked_serial_adder_chunk_add.sv
// ---------------------------------------------------------------------------
// chunk_add
//   Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
//   Parameter CHUNK : slice width in bits.
//   Ports : a, b (CHUNK) and ci in; s (CHUNK) and co out.
// ---------------------------------------------------------------------------
module chunk_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    // The carry chain lives in a procedural variable so the ripple is a
    // single combinational process rather than a self-referencing vector.
    logic carry_v;

    always_comb begin
        carry_v = ci;
        s       = '0;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]    = a[i] ^ b[i] ^ carry_v;
            carry_v = (a[i] & b[i]) | (carry_v & (a[i] ^ b[i]));
        end
        co = carry_v;
    end

endmodule : chunk_add

// File: rtl/chunked_serial_adder.sv
// ---------------------------------------------------------------------------
// chunked_serial_adder
//   Multi-cycle WIDTH-bit adder that processes CHUNK bits per clock through
//   one reused chunk_add slice. Operands are accepted in IDLE, NCHUNK ADD
//   cycles follow, and the result is held in DONE until drained.
//   Parameters : WIDTH (multiple of CHUNK), CHUNK (1..WIDTH)
//   Ports      : clk    - rising-edge clock
//                rst_n  - synchronous active-low reset
//                bus    - chunked_serial_adder_if.slave (operand/result
//                         handshakes, see interface header)
//   Macro      : CSA_SUB_EN - adds the sub port; sub=1 computes in1 - in2
//                with carry = 1 meaning no borrow.
// ---------------------------------------------------------------------------
module chunked_serial_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    chunked_serial_adder_if.slave  bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = cnt_width(NCHUNK);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
            $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               c_reg;
    logic               carry_reg;
    logic [CHUNK-1:0]   sum_chunk_reg [NCHUNK];
    logic [WIDTH-1:0]   sum_packed;

    logic               accept;
    logic               add_last;
    logic               in_ready;
    logic               out_valid;

    logic [CHUNK-1:0]   a_slice;
    logic [CHUNK-1:0]   b_slice;
    logic [CHUNK-1:0]   s_slice;
    logic               co;
    logic [NCHUNK-1:0]  chunk_we;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        add_last   = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = ADD;
                end
            end
            ADD: begin
                if (cnt_reg == LAST_CNT) begin
                    add_last   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Shared chunk slice, fed by the cnt-selected operand slices
    // -----------------------------------------------------------------------
    assign a_slice = a_reg[cnt_reg * CHUNK +: CHUNK];
    assign b_slice = b_reg[cnt_reg * CHUNK +: CHUNK];

    chunk_add #(
        .CHUNK (CHUNK)
    ) u_chunk_add (
        .a  (a_slice),
        .b  (b_slice),
        .ci (c_reg),
        .s  (s_slice),
        .co (co)
    );

    // -----------------------------------------------------------------------
    // Operand registers, chunk counter and running carry. Operands are only
    // loaded on the IDLE accept, so a busy block never samples its inputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            c_reg   <= 1'b0;
            cnt_reg <= '0;
        end else if (accept) begin
            a_reg   <= bus.in1;
            cnt_reg <= '0;
`ifdef CSA_SUB_EN
            // Subtraction as a + ~b + 1; the incoming carry is not used.
            if (bus.sub) begin
                b_reg <= ~bus.in2;
                c_reg <= 1'b1;
            end else begin
                b_reg <= bus.in2;
                c_reg <= bus.cin;
            end
`else
            b_reg   <= bus.in2;
            c_reg   <= bus.cin;
`endif
        end else if (state_reg == ADD) begin
            c_reg <= co;
            // Park the counter at zero after the last chunk so it never
            // indexes past the operands when NCHUNK is not a power of two.
            cnt_reg <= add_last ? '0 : cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_reg <= 1'b0;
        end else if (add_last) begin
            carry_reg <= co;
        end
    end

    // -----------------------------------------------------------------------
    // Result chunks: each one is written only in the ADD cycle that owns it,
    // so chunks not yet reached still show the previous result.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_sum_chunk
            assign chunk_we[gi] = (state_reg == ADD) && (cnt_reg == CNT_W'(gi));

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sum_chunk_reg[gi] <= '0;
                end else if (chunk_we[gi]) begin
                    sum_chunk_reg[gi] <= s_slice;
                end
            end

            assign sum_packed[gi*CHUNK +: CHUNK] = sum_chunk_reg[gi];
        end
    endgenerate

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sum       = sum_packed;
    assign bus.carry     = carry_reg;

endmodule : chunked_serial_adder
